// File: rtl/pix_unpack_pkg.sv
// Shared constants for the pixel unpacker and the VRAM memory interface.
package pix_unpack_pkg;

  localparam int MEM_WORD_BYTES    = 16;
  localparam int MEM_WORD_W        = MEM_WORD_BYTES * 8;
  localparam int DEFAULT_OUT_WIDTH = 32;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry register FIFO; entry0 is always the head, so head and count are plain registers.
module pix_fifo2 #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != 2'd2);
  assign do_pop  = pop  && (cnt != 2'd0);

  always_ff @(posedge clk) begin
    // NOTE: the storage words are reset as well, because the head word drives out_data and it must read 0 after reset.
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) entry0 <= din;
          else             entry1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever is left.
          if (cnt == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign count = cnt;

endmodule

// File: rtl/pix_unpack.sv
// Pixel unpacker: buffers up to two VRAM words and serialises them LSB-first into display beats.
// Optional macro PIX_UNPACK_STATS_EN adds a saturating underrun cycle counter.
module pix_unpack
  import pix_unpack_pkg::*;
#(
  parameter int IN_WIDTH   = MEM_WORD_W,
  parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
  parameter int BEAT_CNT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic [BEAT_CNT_W-1:0] frame_beats,
  input  logic                  active,
  input  logic [IN_WIDTH-1:0]   pix_read,
  input  logic                  pix_read_valid,
  output logic                  pix_read_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [BEAT_CNT_W-1:0] CNT_ONE  = BEAT_CNT_W'(1);

  logic [IN_WIDTH-1:0]               fifo_head;
  logic [1:0]                        fifo_count;
  logic [1:0]                        next_count;
  logic [RATIO-1:0][OUT_WIDTH-1:0]   head_beats;
  logic [IDX_W-1:0]                  idx;
  logic [BEAT_CNT_W-1:0]             beat_cnt;
  logic [BEAT_CNT_W-1:0]             frame_len;
  logic [BEAT_CNT_W-1:0]             last_cmp;
  logic                              bounded;
  logic                              fire;
  logic                              word_done;
  logic                              push_ok;
  logic                              pop_ok;
  logic                              underrun_evt;

  // vsync wins: the coincident word belongs to the previous frame and is discarded.
  assign push_ok      = pix_read_valid && (fifo_count != 2'd2) && !vsync;
  assign fire         = out_valid && out_ready;
  assign word_done    = fire && (idx == IDX_LAST);
  assign pop_ok       = word_done && !vsync;
  assign underrun_evt = active && out_ready && !out_valid && !vsync;

  pix_fifo2 #(
    .WIDTH(IN_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_ok),
    .pop  (pop_ok),
    .flush(vsync),
    .din  (pix_read),
    .head (fifo_head),
    .count(fifo_count)
  );

  assign head_beats = fifo_head;
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = head_beats[idx];
  assign out_last   = out_valid && bounded && (beat_cnt == last_cmp);

  always_comb begin
    // NOTE: next_count gets a default first so no path through this block leaves it unassigned (no latch).
    next_count = fifo_count;
    if (vsync) begin
      next_count = 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   next_count = fifo_count + 2'd1;
        2'b01:   next_count = fifo_count - 2'd1;
        default: next_count = fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every update sees the pre-edge values.
    if (rst) begin
      pix_read_ready <= 1'b0;
      idx            <= '0;
      beat_cnt       <= '0;
      frame_len      <= '0;
      last_cmp       <= '0;
      bounded        <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      pix_read_ready <= (next_count != 2'd2);
      if (vsync) begin
        idx       <= '0;
        beat_cnt  <= '0;
        underrun  <= 1'b0;
        frame_len <= frame_beats;
        last_cmp  <= frame_beats - CNT_ONE;
        bounded   <= (frame_beats != '0);
      end else begin
        if (fire) idx <= word_done ? '0 : idx + IDX_ONE;
        // Counter parks at frame_len once the frame's last beat has gone.
        if (fire && (!bounded || (beat_cnt != frame_len))) beat_cnt <= beat_cnt + CNT_ONE;
        if (underrun_evt) underrun <= 1'b1;
      end
    end
  end

`ifdef PIX_UNPACK_STATS_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt_q <= 16'h0000;
    end else if (underrun_evt && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'h0001;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`else
  assign underrun_cnt = 16'h0000;
`endif

  // Writing into a full buffer is a producer bug; the word is dropped.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(pix_read_valid && (fifo_count == 2'd2) && !vsync));

endmodule
